// File: rtl/dmi_req_arbiter.sv
// Round-robin share of one DMI channel between two requesters; optional response timeout under DMI_ARB_TIMEOUT_EN.
// Latency: accept cycle 0, downstream request cycle 1, response cycle 3 earliest (local NOP/reserved ops: cycle 1).
// Backpressure: one transaction in flight; requests and responses hold stable until their ready handshakes.
module dmi_req_arbiter #(
    parameter int ABITS          = 7,
    parameter int DBITS          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         req_valid_i,
    output logic [1:0]         req_ready_o,
    input  logic [2*ABITS-1:0] req_addr_i,
    input  logic [2*DBITS-1:0] req_data_i,
    input  logic [3:0]         req_op_i,
    output logic [1:0]         rsp_valid_o,
    input  logic [1:0]         rsp_ready_i,
    output logic [DBITS-1:0]   rsp_data_o,
    output logic [1:0]         rsp_resp_o,
    output logic               dmi_req_valid_o,
    input  logic               dmi_req_ready_i,
    output logic [ABITS-1:0]   dmi_req_addr_o,
    output logic [DBITS-1:0]   dmi_req_data_o,
    output logic [1:0]         dmi_req_op_o,
    input  logic               dmi_rsp_valid_i,
    output logic               dmi_rsp_ready_o,
    input  logic [DBITS-1:0]   dmi_rsp_data_i,
    input  logic [1:0]         dmi_rsp_resp_i,
    output logic               busy_o,
    output logic               owner_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESPOND} state_e;

    state_e             state_q, state_d;
    logic               last_grant_q, owner_q;
    logic [ABITS-1:0]   addr_q;
    logic [DBITS-1:0]   data_q;
    logic [1:0]         op_q;
    logic [DBITS-1:0]   rsp_data_q;
    logic [1:0]         rsp_resp_q;

    logic               grant_en, grant_idx, accept;
    logic               rsp_take, timeout_take, timeout_hit, drain_pending;
    logic [ABITS-1:0]   sel_addr;
    logic [DBITS-1:0]   sel_data;
    logic [1:0]         sel_op;

    always_comb begin
        grant_idx = 1'b0;
        case (req_valid_i)
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant_q;
            default: grant_idx = 1'b0;
        endcase
    end

    // No grant while a timed-out response is still owed by the debug module.
    assign grant_en = (state_q == IDLE) && !drain_pending && (|req_valid_i) && !rst_i;
    assign sel_addr = grant_idx ? req_addr_i[2*ABITS-1:ABITS] : req_addr_i[ABITS-1:0];
    assign sel_data = grant_idx ? req_data_i[2*DBITS-1:DBITS] : req_data_i[DBITS-1:0];
    assign sel_op   = grant_idx ? req_op_i[3:2] : req_op_i[1:0];

    always_comb begin
        state_d         = state_q;
        req_ready_o     = 2'b00;
        rsp_valid_o     = 2'b00;
        dmi_req_valid_o = 1'b0;
        dmi_rsp_ready_o = 1'b0;
        accept          = 1'b0;
        rsp_take        = 1'b0;
        timeout_take    = 1'b0;
        case (state_q)
            IDLE: begin
                dmi_rsp_ready_o = drain_pending;
                if (grant_en) begin
                    req_ready_o[grant_idx] = 1'b1;
                    accept                 = 1'b1;
                    state_d = (sel_op == 2'd1 || sel_op == 2'd2) ? ISSUE : RESPOND;
                end
            end
            ISSUE: begin
                dmi_req_valid_o = 1'b1;
                if (dmi_req_ready_i) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                dmi_rsp_ready_o = 1'b1;
                if (dmi_rsp_valid_i) begin
                    rsp_take = 1'b1;
                    state_d  = RESPOND;
                end else if (timeout_hit) begin
                    timeout_take = 1'b1;
                    state_d      = RESPOND;
                end
            end
            RESPOND: begin
                rsp_valid_o[owner_q] = 1'b1;
                if (rsp_ready_i[owner_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            op_q         <= 2'd0;
            rsp_data_q   <= '0;
            rsp_resp_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q       <= sel_addr;
                data_q       <= sel_data;
                op_q         <= sel_op;
                owner_q      <= grant_idx;
                last_grant_q <= grant_idx;
                // Local completions: NOP answers ok, reserved answers failed.
                if (sel_op == 2'd0 || sel_op == 2'd3) begin
                    rsp_data_q <= '0;
                    rsp_resp_q <= (sel_op == 2'd0) ? 2'd0 : 2'd2;
                end
            end
            if (rsp_take) begin
                rsp_data_q <= dmi_rsp_data_i;
                rsp_resp_q <= dmi_rsp_resp_i;
            end else if (timeout_take) begin
                rsp_data_q <= '0;
                rsp_resp_q <= 2'd3;
            end
        end
    end

`ifdef DMI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic             drain_q;

    assign timeout_hit   = (state_q == WAIT_RSP) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign drain_pending = drain_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == WAIT_RSP) ? cnt_q + CNT_W'(1) : '0;
            if (timeout_take)
                drain_q <= 1'b1;
            else if (drain_q && (state_q == IDLE) && dmi_rsp_valid_i)
                drain_q <= 1'b0;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign drain_pending      = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 1);
`endif

    assign rsp_data_o     = rsp_data_q;
    assign rsp_resp_o     = rsp_resp_q;
    assign dmi_req_addr_o = addr_q;
    assign dmi_req_data_o = data_q;
    assign dmi_req_op_o   = op_q;
    assign busy_o         = (state_q != IDLE);
    assign owner_o        = owner_q;

endmodule

// File: doc/dmi_req_arbiter.md
Name: dmi_req_arbiter

Overview:
- Shares one debug-module DMI request/response channel between two requesters: port 0 is the JTAG DTM and port 1 is a secondary debugger (e.g. a system-bus bridge).
- Exactly one transaction is outstanding at a time. Requesters are granted round-robin.
- The block sequences each grant through request issue, response wait and response return.
- NOP and reserved ops complete locally and never reach the debug module.

Parameters:
- ABITS, 7, DMI address width.
- DBITS, 32, DMI data width.
- TIMEOUT_CYCLES, 1024, response timeout in cycles. Used only when DMI_ARB_TIMEOUT_EN is defined. Must be ≥ 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  2  request valid, bit n = requester n
- req_ready_o  out  2  request accepted (one-hot or zero)
- req_addr_i  in  2*ABITS  packed addresses, requester n at [n*ABITS +: ABITS]
- req_data_i  in  2*DBITS  packed write data
- req_op_i  in  4  packed ops, 2 bits each: 0 NOP, 1 read, 2 write, 3 reserved
- rsp_valid_o  out  2  response valid, one-hot to the owner
- rsp_ready_i  in  2  response ready per requester
- rsp_data_o  out  DBITS  response data, shared by both requesters
- rsp_resp_o  out  2  response code: 0 ok, 2 failed, 3 busy
- dmi_req_valid_o  out  1  downstream request valid
- dmi_req_ready_i  in  1  downstream request ready
- dmi_req_addr_o  out  ABITS  downstream address
- dmi_req_data_o  out  DBITS  downstream write data
- dmi_req_op_o  out  2  downstream op (1 or 2 only)
- dmi_rsp_valid_i  in  1  downstream response valid
- dmi_rsp_ready_o  out  1  downstream response ready
- dmi_rsp_data_i  in  DBITS  downstream response data
- dmi_rsp_resp_i  in  2  downstream response code
- busy_o  out  1  state != IDLE
- owner_o  out  1  index of the current or last granted requester

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - State goes to IDLE; last_grant=1, so requester 0 wins the first contest.
  - Captured addr/data/op/rsp registers are cleared.
  - All outputs are 0.
  - Reset mid-transaction abandons the transaction silently. The downstream side shares this reset.
- FSM states: IDLE, ISSUE, WAIT_RSP, RESPOND.
- IDLE:
  - Grant: if exactly one req_valid_i bit is set, that requester wins. If both are set, the requester != last_grant wins.
  - req_ready_o[g] is combinational, =1 in IDLE for the granted requester only. The handshake completes the same cycle.
  - On accept: latch addr/data/op, set owner=g and last_grant=g.
  - op 1 or 2 → ISSUE.
  - op 0 → RESPOND with resp 0, data 0.
  - op 3 → RESPOND with resp 2, data 0.
- ISSUE:
  - dmi_req_valid_o=1, driving the latched addr/data/op. These stay stable until dmi_req_ready_i.
  - Handshake → WAIT_RSP.
- WAIT_RSP:
  - dmi_rsp_ready_o=1.
  - On dmi_rsp_valid_i: capture dmi_rsp_data_i/dmi_rsp_resp_i → RESPOND.
- RESPOND:
  - rsp_valid_o[owner]=1; rsp_data_o and rsp_resp_o hold the captured values.
  - When rsp_ready_i[owner]=1 → IDLE. rsp_ready_i of the non-owner is ignored.
- Latency: accept in cycle 0; dmi_req_valid_o at cycle 1. With zero-wait downstream, rsp_valid_o is at cycle 3 at the earliest. Local ops give rsp_valid_o at cycle 1.
- The next accept occurs no earlier than the cycle after the RESPOND handshake. Max throughput is 1 transaction / 4 cycles.
- A requester dropping req_valid_i before accept is legal. Its stale valid bit is never granted.
- In IDLE, rsp_data_o and rsp_resp_o hold their last values; rsp_valid_o=0.

Optional Feature:
- Macro: DMI_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_RSP and increments each WAIT_RSP cycle.
  - If the count reaches TIMEOUT_CYCLES-1 without dmi_rsp_valid_i → RESPOND with resp 3 (busy), data 0, and set drain_pending.
  - While drain_pending: dmi_rsp_ready_o=1 in IDLE and no grants occur. The first dmi_rsp_valid_i is discarded and clears drain_pending.
  - A response arriving in the same cycle as expiry wins, and no timeout is taken.
  - Reset clears the counter and drain_pending.
- Undefined: no counter and no drain logic; WAIT_RSP waits indefinitely.

Test Plan:
- Requester 0 read, addr 7'h11, downstream returns data 32'hDEADBEEF, resp 0, zero wait → rsp_valid_o=2'b01 at cycle 3 with data DEADBEEF and resp 0; busy_o back to 0 after the handshake.
- Both requesters hold writes continuously (addr 7'h10 and 7'h04) → downstream sees the owner sequence 0,1,0,1, each with the correct addr/data; req_ready_o is never 2'b11.
- Requester 1 issues op 0 then op 3 → dmi_req_valid_o stays 0; responses are resp 0 then resp 2, data 0, each at cycle 1.
- dmi_req_ready_i held low 5 cycles, then rsp_ready_i[0] held low 3 cycles → dmi_req_* and rsp_* stay stable throughout; there is exactly one downstream request and one response.
- rst_i asserted during WAIT_RSP → next cycle: all outputs 0, state IDLE; a fresh requester-0 read then completes normally.
- DMI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no downstream response → resp 3 after 8 WAIT_RSP cycles; a pending requester-1 request is blocked until the late dmi_rsp_valid_i is drained, then is granted.
